// File: rtl/ifft_config_receiver_pkg.sv
// rtl/ifft_config_receiver_pkg.sv - shared field layout, state encoding and decoded-config type
//
// Purpose : constants shared by the config driver and the receiver.
//           Covers the config word field offsets and widths, and the EMPTY/HELD state encoding.
// Ports   : none (package)
// Config  : IFFT_CFG_STATS_EN (optional statistics counters, used in ifft_config_receiver)
package ifft_config_receiver_pkg;

   localparam int CFG_W     = 24;
   localparam int NFFT_LSB  = 0;
   localparam int NFFT_W    = 4;
   localparam int FWD_BIT   = 8;
   localparam int SCALE_LSB = 9;
   localparam int SCALE_W   = 14;

   typedef enum logic {
      EMPTY = 1'b0,
      HELD  = 1'b1
   } state_t;

   typedef struct packed {
      logic [NFFT_W-1:0]  nfft;
      logic               fwd;
      logic [SCALE_W-1:0] scale;
   } cfg_fields_t;

endpackage

// File: rtl/ifft_config_receiver_if.sv
// rtl/ifft_config_receiver_if.sv - 24-bit IFFT config stream interface
//
// Purpose : groups the config stream handshake signals.
// Signals : tData  24  config word (driven by master)
//           tValid 1   word valid (driven by master)
//           tReady 1   slave can accept (driven by slave)
// Config  : IFFT_CFG_STATS_EN has no effect here
interface ifft_config_receiver_if;

   logic [23:0] tData;
   logic        tValid;
   logic        tReady;

   modport master (output tData, output tValid, input tReady);
   modport slave  (input tData, input tValid, output tReady);

endinterface

// File: rtl/ifft_config_receiver_field_decode.sv
// rtl/ifft_config_receiver_field_decode.sv - combinational split of a config word into fields
//
// Purpose : extracts nfft / fwd / scale from a config word.
//           Flags whether nfft lies in [NFFT_MIN, NFFT_MAX].
// Ports   : word   in  24  raw config word
//           fields out     decoded nfft/fwd/scale
//           legal  out 1   nfft within the legal range
// Config  : IFFT_CFG_STATS_EN has no effect here
module ifft_cfg_field_decode
   import ifft_config_receiver_pkg::*;
#(
   parameter int NFFT_MIN = 3,
   parameter int NFFT_MAX = 12
) (
   input  logic [CFG_W-1:0] word,
   output cfg_fields_t      fields,
   output logic             legal
);

   // Reserved bits [7:4] and [23] are deliberately not part of the decode.
   logic unused_rsvd;
   assign unused_rsvd = ^{word[7:4], word[23]};

   assign fields.nfft  = word[NFFT_LSB +: NFFT_W];
   assign fields.fwd   = word[FWD_BIT];
   assign fields.scale = word[SCALE_LSB +: SCALE_W];

   assign legal = (fields.nfft >= NFFT_W'(NFFT_MIN)) &&
                  (fields.nfft <= NFFT_W'(NFFT_MAX));

endmodule

// File: rtl/ifft_config_receiver.sv
// rtl/ifft_config_receiver.sv - config stream slave with one-deep hold and idle-gated apply
//
// Purpose : accepts range-checked config words into a one-deep hold register.
//           Applies the held word to the active settings only while the engine is idle.
// Ports   : CLK, RST_N          clock, async active-low reset
//           cfg (slave)         tData/tValid/tReady config stream
//           engine_idle   in  1 engine between frames
//           active_nfft   out 4 applied log2 frame size
//           active_fwd    out 1 applied direction (1 = forward)
//           active_scale  out 14 applied scale schedule
//           pending       out 1 validated word held, not yet applied
//           cfg_applied   out 1 pulse: active_* updated
//           cfg_error     out 1 pulse: word rejected
//           cfg_count     out 16 (IFFT_CFG_STATS_EN) applied words, wrapping
//           err_count     out 8  (IFFT_CFG_STATS_EN) rejected words, saturating
// Config  : IFFT_CFG_STATS_EN adds cfg_count / err_count
module ifft_config_receiver
   import ifft_config_receiver_pkg::*;
#(
   parameter int              NFFT_MIN    = 3,
   parameter int              NFFT_MAX    = 12,
   parameter int              RESET_NFFT  = 10,
   parameter logic [SCALE_W-1:0] RESET_SCALE = 14'h2AAA
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   ifft_config_receiver_if.slave cfg,
   input  logic                 engine_idle,
   output logic [NFFT_W-1:0]    active_nfft,
   output logic                 active_fwd,
   output logic [SCALE_W-1:0]   active_scale,
   output logic                 pending,
   output logic                 cfg_applied,
   output logic                 cfg_error
`ifdef IFFT_CFG_STATS_EN
   ,
   output logic [15:0]          cfg_count,
   output logic [7:0]           err_count
`endif
);

   state_t      state, state_nxt;
   cfg_fields_t hold_q;
   cfg_fields_t dec;
   logic        legal;
   logic        capture;
   logic        apply_nxt;
   logic        err_nxt;
   logic        ready_nxt;
   logic        pend_nxt;

   ifft_cfg_field_decode #(
      .NFFT_MIN (NFFT_MIN),
      .NFFT_MAX (NFFT_MAX)
   ) u_decode (
      .word   (cfg.tData),
      .fields (dec),
      .legal  (legal)
   );

   // Accept only happens in EMPTY and apply only in HELD, so the two can never
   // share an edge; a word accepted at one edge applies at the next at the earliest.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      apply_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         EMPTY: begin
            if (cfg.tValid && cfg.tReady) begin
               if (legal) begin
                  capture   = 1'b1;
                  state_nxt = HELD;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         HELD: begin
            if (engine_idle) begin
               apply_nxt = 1'b1;
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // tReady and pending are registered copies of the upcoming state so they
      // flip on the same edge that changes state; tReady stays 0 throughout reset.
      ready_nxt = (state_nxt == EMPTY);
      pend_nxt  = (state_nxt == HELD);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= EMPTY;
         cfg.tReady   <= 1'b0;
         pending      <= 1'b0;
         cfg_applied  <= 1'b0;
         cfg_error    <= 1'b0;
         hold_q       <= '0;
         active_nfft  <= NFFT_W'(RESET_NFFT);
         active_fwd   <= 1'b1;
         active_scale <= RESET_SCALE;
      end else begin
         state       <= state_nxt;
         cfg.tReady  <= ready_nxt;
         pending     <= pend_nxt;
         cfg_applied <= apply_nxt;
         cfg_error   <= err_nxt;
         if (capture) begin
            hold_q <= dec;
         end
         if (apply_nxt) begin
            active_nfft  <= hold_q.nfft;
            active_fwd   <= hold_q.fwd;
            active_scale <= hold_q.scale;
         end
      end
   end

`ifdef IFFT_CFG_STATS_EN
   // Counters step on the same edge that raises the matching pulse.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cfg_count <= '0;
         err_count <= '0;
      end else begin
         if (apply_nxt) begin
            cfg_count <= cfg_count + 16'd1;
         end
         if (err_nxt && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end
`endif

endmodule
